keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan
//
// Scans a 4x4 matrix keypad one column at a time, debounces a single key
// press and its release, and reports the accepted key as a hex code.
//
// Parameters
//   SCAN_DIV      clock cycles each column is driven (min 4)
//   DEBOUNCE_CNT  consecutive stable cycles needed to accept a press or
//                 a release (min 2)
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous, active-high reset
//   row_in     keypad rows, active-low, pulled up, asynchronous to clk
//   col_out    column drive, active-low, exactly one bit low at all times
//   key_code   hex code of the most recently accepted key
//   key_valid  one-cycle pulse when a key is accepted
//   key_held   high from acceptance until the release is accepted
//   disp_val   registered copy of key_code for the 7-segment decoder
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | walk the columns, sample rows on the last cycle of a dwell
// DEBOUNCE | column held, counting cycles the captured row stays low
// PRESSED  | key accepted, column held, waiting for all rows high
// RELEASE  | counting cycles all rows stay high before re-arming
// ---------------------------------------------------------------------------
module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] disp_val
);

  // Both timers are down-counters loaded with N-1 and terminating at zero,
  // so $clog2(N) bits always suffice and the count can never wrap.
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       row_meta_q;
  logic [3:0]       row_sync_q;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_out_q, col_out_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [3:0]       disp_val_q, disp_val_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic             one_low;
  logic [1:0]       low_idx;
  logic [3:0]       cap_pattern;
  logic             rows_idle;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer; idles high so a reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
    end
  end

  // Only a single low row identifies a key; multiple lows are ghosting or
  // a multi-key chord and are rejected.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (row_sync_q)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign cap_pattern = ~(4'b0001 << row_idx_q);
  assign rows_idle   = (row_sync_q == 4'b1111);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    div_cnt_d   = div_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SCAN: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = DIV_LOAD;
          if (one_low) begin
            row_idx_d = low_idx;
            deb_cnt_d = DEB_LOAD;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (row_sync_q != cap_pattern) begin
          deb_cnt_d = DEB_LOAD;
          div_cnt_d = DIV_LOAD;
          col_d     = col_q + 2'd1;
          state_d   = ST_SCAN;
        end else if (deb_cnt_q == '0) begin
          key_code_d  = key_map(row_idx_q, col_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = ST_PRESSED;
        end else begin
          deb_cnt_d = deb_cnt_q - 1'b1;
        end
      end

      ST_PRESSED: begin
        // Other keys in the held column are ignored; only all-rows-high
        // starts the release qualification.
        if (rows_idle) begin
          deb_cnt_d = DEB_LOAD;
          state_d   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (!rows_idle) begin
          deb_cnt_d = DEB_LOAD;
          state_d   = ST_PRESSED;
        end else if (deb_cnt_q == '0) begin
          key_held_d = 1'b0;
          div_cnt_d  = DIV_LOAD;
          col_d      = col_q + 2'd1;
          state_d    = ST_SCAN;
        end else begin
          deb_cnt_d = deb_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase

    col_out_d  = ~(4'b0001 << col_d);
    disp_val_d = key_code_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      col_out_q   <= 4'b1110;
      div_cnt_q   <= DIV_LOAD;
      deb_cnt_q   <= DEB_LOAD;
      row_idx_q   <= 2'd0;
      key_code_q  <= 4'h0;
      disp_val_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      col_out_q   <= col_out_d;
      div_cnt_q   <= div_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      row_idx_q   <= row_idx_d;
      key_code_q  <= key_code_d;
      disp_val_q  <= disp_val_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = key_code_q;
  assign disp_val  = disp_val_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
